lcd_bus_monitor: RTL and testbench

//  Receiving end of the HD44780-style character-LCD write bus (LCD_DATA/RS/RW/EN), i.e. the

---
 rtl/lcd_bus_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_monitor.sv
// Display-side model of an HD44780-style write bus: 2x16 shadow buffer, address counter, busy timing.
// Strobe decoded 3 cycles after EN falls; read port 1-cycle latency; no backpressure, strobes while busy are dropped and flagged.
module lcd_bus_monitor #(
    parameter int SHORT_CYC = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int CNT_W     = 17
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iLCD_DATA,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic       iLCD_EN,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_CHAR,
    output logic [6:0] oADDR,
    output logic       oBUSY,
    output logic       oDISP_ON,
    output logic       oENTRY_INC,
    output logic       oWR_STB,
    output logic       oERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_EXEC
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [4:0]         clr_idx, clr_nxt;

    // {rw, rs, en, data} travel together through the synchronizer
    logic [10:0]        sync1, sync2;
    logic               en_d;
    logic               stb;
    logic [7:0]         cap_dat;
    logic               cap_rs;
    logic               cap_rw;

    logic [7:0]         mem [32];

    logic [6:0]         addr_nxt;
    logic               disp_nxt;
    logic               entry_nxt;
    logic               err_nxt;
    logic               wr_en;
    logic [4:0]         wr_idx;
    logic [7:0]         wr_dat;
    logic               data_hit;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1   <= '0;
            sync2   <= '0;
            en_d    <= 1'b0;
            stb     <= 1'b0;
            cap_dat <= '0;
            cap_rs  <= 1'b0;
            cap_rw  <= 1'b0;
        end else begin
            sync1 <= {iLCD_RW, iLCD_RS, iLCD_EN, iLCD_DATA};
            sync2 <= sync1;
            en_d  <= sync2[8];
            stb   <= en_d & ~sync2[8];
            if (sync2[8]) begin
                cap_dat <= sync2[7:0];
                cap_rs  <= sync2[9];
                cap_rw  <= sync2[10];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= ST_CLEAR;
            cnt     <= '0;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            clr_idx <= clr_nxt;
        end
    end

    assign oBUSY = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_nxt   = clr_idx;
        addr_nxt  = oADDR;
        disp_nxt  = oDISP_ON;
        entry_nxt = oENTRY_INC;
        err_nxt   = oERR;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_dat    = '0;
        data_hit  = 1'b0;

        case (state)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = clr_idx;
                wr_dat  = 8'h20;
                clr_nxt = clr_idx + 5'd1;
                if (clr_idx == 5'd31) begin
                    // the 32 clear cycles count toward the long busy time
                    if (LONG_CYC > 32) begin
                        state_nxt = ST_EXEC;
                        cnt_nxt   = CNT_W'(LONG_CYC - 33);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: begin
                if (stb && !cap_rw) begin
                    if (cap_rs) begin
                        if (oADDR[6:4] == 3'b000 || oADDR[6:4] == 3'b100) begin
                            data_hit = 1'b1;
                            wr_en    = 1'b1;
                            wr_idx   = {oADDR[6], oADDR[3:0]};
                            wr_dat   = cap_dat;
                        end
                        if (oENTRY_INC) begin
                            case (oADDR)
                                7'h27:   addr_nxt = 7'h40;
                                7'h67:   addr_nxt = 7'h00;
                                default: addr_nxt = oADDR + 7'd1;
                            endcase
                        end else begin
                            case (oADDR)
                                7'h40:   addr_nxt = 7'h27;
                                7'h00:   addr_nxt = 7'h67;
                                default: addr_nxt = oADDR - 7'd1;
                            endcase
                        end
                        state_nxt = ST_EXEC;
                        cnt_nxt   = CNT_W'(SHORT_CYC - 1);
                    end else begin
                        casez (cap_dat)
                            8'b1???????: begin
                                addr_nxt  = cap_dat[6:0];
                                state_nxt = ST_EXEC;
                                cnt_nxt   = CNT_W'(SHORT_CYC - 1);
                            end
                            8'b01??????, 8'b001?????, 8'b0001????: begin
                                state_nxt = ST_EXEC;
                                cnt_nxt   = CNT_W'(SHORT_CYC - 1);
                            end
                            8'b00001???: begin
                                disp_nxt  = cap_dat[2];
                                state_nxt = ST_EXEC;
                                cnt_nxt   = CNT_W'(SHORT_CYC - 1);
                            end
                            8'b000001??: begin
                                entry_nxt = cap_dat[1];
                                state_nxt = ST_EXEC;
                                cnt_nxt   = CNT_W'(SHORT_CYC - 1);
                            end
                            8'b0000001?: begin
                                addr_nxt  = 7'h00;
                                state_nxt = ST_EXEC;
                                cnt_nxt   = CNT_W'(LONG_CYC - 1);
                            end
                            8'b00000001: begin
                                addr_nxt  = 7'h00;
                                entry_nxt = 1'b1;
                                state_nxt = ST_CLEAR;
                                clr_nxt   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (stb && !cap_rw && oBUSY) err_nxt = 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oADDR      <= '0;
            oDISP_ON   <= 1'b0;
            oENTRY_INC <= 1'b1;
            oERR       <= 1'b0;
            oWR_STB    <= 1'b0;
            oRD_CHAR   <= '0;
        end else begin
            oADDR      <= addr_nxt;
            oDISP_ON   <= disp_nxt;
            oENTRY_INC <= entry_nxt;
            oERR       <= err_nxt;
            oWR_STB    <= data_hit;
            oRD_CHAR   <= mem[iRD_ADDR];
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en) mem[wr_idx] <= wr_dat;
    end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomized and directed bench for lcd_bus_monitor against a transaction-level display model.
module tb_lcd_bus_monitor;

    localparam int SHORT = 8;
    localparam int LONG  = 40;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] iLCD_DATA = '0;
    logic       iLCD_RS = 1'b0;
    logic       iLCD_RW = 1'b0;
    logic       iLCD_EN = 1'b0;
    logic [4:0] iRD_ADDR = '0;
    logic [7:0] oRD_CHAR;
    logic [6:0] oADDR;
    logic       oBUSY, oDISP_ON, oENTRY_INC, oWR_STB, oERR;

    lcd_bus_monitor #(.SHORT_CYC(SHORT), .LONG_CYC(LONG), .CNT_W(17)) dut (
        .iCLK(iCLK), .iRST(iRST), .iLCD_DATA(iLCD_DATA), .iLCD_RS(iLCD_RS),
        .iLCD_RW(iLCD_RW), .iLCD_EN(iLCD_EN), .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR),
        .oADDR(oADDR), .oBUSY(oBUSY), .oDISP_ON(oDISP_ON), .oENTRY_INC(oENTRY_INC),
        .oWR_STB(oWR_STB), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;

    always @(negedge iCLK) if (oWR_STB === 1'b1) stb_cnt++;

    // reference model of the display
    logic [7:0] m_mem [32];
    int         m_addr;
    bit         m_disp, m_entry, m_err;
    int         m_wr;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_addr = 0; m_disp = 0; m_entry = 1; m_err = 0;
    endtask

    task automatic m_cmd(input logic [7:0] c);
        if (c[7])                   m_addr = int'(c[6:0]);
        else if (c[6] | c[5] | c[4]) ;
        else if (c[3])              m_disp = c[2];
        else if (c[2])              m_entry = c[1];
        else if (c[1])              m_addr = 0;
        else if (c[0]) begin
            m_addr = 0; m_entry = 1;
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        end
    endtask

    task automatic m_data(input logic [7:0] d);
        if (m_addr < 16) begin
            m_mem[m_addr] = d; m_wr++;
        end else if (m_addr >= 64 && m_addr < 80) begin
            m_mem[m_addr - 48] = d; m_wr++;
        end
        if (m_entry) m_addr = (m_addr == 39) ? 64 : (m_addr == 103) ? 0 : (m_addr + 1) % 128;
        else         m_addr = (m_addr == 64) ? 39 : (m_addr == 0) ? 103 : (m_addr + 127) % 128;
    endtask

    function automatic logic [255:0] m_snap();
        logic [255:0] s;
        for (int i = 0; i < 32; i++) s[i*8 +: 8] = m_mem[i];
        return s;
    endfunction

    task automatic read_all(output logic [255:0] s);
        for (int i = 0; i < 32; i++) begin
            @(negedge iCLK); iRD_ADDR = 5'(i);
            @(negedge iCLK); s[i*8 +: 8] = oRD_CHAR;
        end
    endtask

    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input int hi, input int lo);
        @(negedge iCLK);
        iLCD_DATA = d; iLCD_RS = rs; iLCD_RW = rw; iLCD_EN = 1'b1;
        repeat (hi) @(negedge iCLK);
        iLCD_EN = 1'b0;
        repeat (lo) @(negedge iCLK);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (oBUSY !== 1'b0 && n < 400) begin @(negedge iCLK); n++; end
        total++;
        if (oBUSY !== 1'b0) begin
            bad++; $display("FAIL %s idle-timeout: busy=%b required 0", tag, oBUSY);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        strobe(0, 0, c, 4, 5); m_cmd(c); wait_idle("cmd");
    endtask

    task automatic send_data(input logic [7:0] d);
        strobe(1, 0, d, 4, 5); m_data(d); wait_idle("data");
    endtask

    task automatic hold_reset();
        @(negedge iCLK); iRST = 1'b1; iLCD_EN = 1'b0;
        repeat (3) @(negedge iCLK);
        m_reset();
    endtask

    task automatic release_reset(output int n);
        iRST = 1'b0; n = 0;
        while (oBUSY === 1'b1 && n < 200) begin n++; @(negedge iCLK); end
    endtask

    task automatic test_reset();
        int n; logic [255:0] s;
        hold_reset();
        total += 5;
        if (oADDR !== 7'h00)   begin bad++; $display("FAIL rst_addr got=%h exp=00", oADDR); end
        if (oENTRY_INC !== 1)  begin bad++; $display("FAIL rst_entry got=%b exp=1", oENTRY_INC); end
        if (oDISP_ON !== 0 || oERR !== 0 || oWR_STB !== 0)
            begin bad++; $display("FAIL rst_flags got disp=%b err=%b stb=%b exp 000", oDISP_ON, oERR, oWR_STB); end
        if (oRD_CHAR !== 8'h00) begin bad++; $display("FAIL rst_rdchar got=%h exp=00", oRD_CHAR); end
        if (oBUSY !== 1)       begin bad++; $display("FAIL rst_busy got=%b exp=1", oBUSY); end
        release_reset(n);
        total++;
        if (n != LONG) begin bad++; $display("FAIL rst_busy_len got=%0d exp=%0d", n, LONG); end
        read_all(s);
        total += 2;
        if (s !== m_snap()) begin bad++; $display("FAIL rst_buffer got=%h exp=%h", s, m_snap()); end
        if (oADDR !== 7'h00) begin bad++; $display("FAIL rst_addr_idle got=%h exp=00", oADDR); end
    endtask

    task automatic test_basic_seq();
        logic [255:0] s; int w0 = stb_cnt;
        m_wr = 0;
        send_cmd(8'h38); send_cmd(8'h0C); send_cmd(8'h01); send_cmd(8'h06); send_cmd(8'h80);
        send_data(8'h57); send_data(8'h65);
        read_all(s);
        total += 5;
        if (oDISP_ON !== 1'b1) begin bad++; $display("FAIL basic_disp got=%b exp=1", oDISP_ON); end
        if (s[7:0] !== 8'h57 || s[15:8] !== 8'h65) begin bad++; $display("FAIL basic_idx01 got=%h%h exp=6557", s[15:8], s[7:0]); end
        if (s !== m_snap()) begin bad++; $display("FAIL basic_buffer got=%h exp=%h", s, m_snap()); end
        if (oADDR !== 7'h02) begin bad++; $display("FAIL basic_addr got=%h exp=02", oADDR); end
        if (stb_cnt - w0 != 2) begin bad++; $display("FAIL basic_wrstb got=%0d exp=2", stb_cnt - w0); end
    endtask

    task automatic test_line2_gap();
        logic [255:0] s; int w0 = stb_cnt;
        send_cmd(8'hC0); send_data(8'h41);
        total++;
        if (oADDR !== 7'h41) begin bad++; $display("FAIL line2_addr got=%h exp=41", oADDR); end
        send_cmd(8'h8F); send_data(8'h42); send_data(8'h43);
        read_all(s);
        total += 4;
        if (s[16*8 +: 8] !== 8'h41 || s[15*8 +: 8] !== 8'h42)
            begin bad++; $display("FAIL line2_idx got16=%h got15=%h exp 41/42", s[16*8 +: 8], s[15*8 +: 8]); end
        if (s !== m_snap()) begin bad++; $display("FAIL line2_buffer got=%h exp=%h", s, m_snap()); end
        if (oADDR !== 7'h11) begin bad++; $display("FAIL gap_addr got=%h exp=11", oADDR); end
        if (stb_cnt - w0 != 2) begin bad++; $display("FAIL gap_wrstb got=%0d exp=2", stb_cnt - w0); end
    endtask

    task automatic test_wrap();
        logic [255:0] s; int w0 = stb_cnt;
        send_cmd(8'hA7); send_data(8'h58);
        total += 2;
        if (oADDR !== 7'h40) begin bad++; $display("FAIL wrap_inc got=%h exp=40", oADDR); end
        if (stb_cnt != w0)   begin bad++; $display("FAIL wrap_nowrite pulses=%0d exp=0", stb_cnt - w0); end
        send_cmd(8'h04); send_cmd(8'h80); send_data(8'h33);
        read_all(s);
        total += 3;
        if (oADDR !== 7'h67) begin bad++; $display("FAIL wrap_dec got=%h exp=67", oADDR); end
        if (oENTRY_INC !== 1'b0) begin bad++; $display("FAIL wrap_entry got=%b exp=0", oENTRY_INC); end
        if (s !== m_snap()) begin bad++; $display("FAIL wrap_buffer got=%h exp=%h", s, m_snap()); end
    endtask

    task automatic test_random();
        logic [255:0] s; int w0 = stb_cnt; int wm = m_wr; int op; logic [7:0] b;
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            b  = 8'($urandom);
            case (op)
                0, 1, 2, 3, 4: send_data(b);
                5: send_cmd(8'h80 | b);
                6: send_cmd(8'h04 | (b & 8'h03));
                7: send_cmd(8'h08 | (b & 8'h07));
                8: send_cmd(8'h02 | (b & 8'h01));
                default: begin
                    if (b[0]) send_cmd(8'h00);
                    else begin strobe(b[1], 1, b, 4, 5); wait_idle("rw"); end
                end
            endcase
        end
        read_all(s);
        total += 6;
        if (s !== m_snap()) begin bad++; $display("FAIL rand_buffer got=%h exp=%h", s, m_snap()); end
        if (int'(oADDR) != m_addr) begin bad++; $display("FAIL rand_addr got=%h exp=%h", oADDR, m_addr); end
        if (oDISP_ON !== m_disp) begin bad++; $display("FAIL rand_disp got=%b exp=%b", oDISP_ON, m_disp); end
        if (oENTRY_INC !== m_entry) begin bad++; $display("FAIL rand_entry got=%b exp=%b", oENTRY_INC, m_entry); end
        if (oERR !== 1'b0) begin bad++; $display("FAIL rand_err got=%b exp=0", oERR); end
        if (stb_cnt - w0 != m_wr - wm) begin bad++; $display("FAIL rand_wrstb got=%0d exp=%0d", stb_cnt - w0, m_wr - wm); end
    endtask

    task automatic test_busy_err();
        logic [255:0] s; int n = 0; int w0;
        strobe(0, 0, 8'h06, 4, 1); m_cmd(8'h06);
        while (oBUSY !== 1'b1 && n < 20) begin @(negedge iCLK); n++; end
        total++;
        if (oBUSY !== 1'b1) begin bad++; $display("FAIL err_busy_rise got=%b exp=1", oBUSY); end
        w0 = stb_cnt;
        strobe(1, 0, 8'h5A, 1, 1);
        m_err = 1;
        wait_idle("err");
        read_all(s);
        total += 4;
        if (oERR !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", oERR); end
        if (int'(oADDR) != m_addr) begin bad++; $display("FAIL err_addr got=%h exp=%h", oADDR, m_addr); end
        if (s !== m_snap()) begin bad++; $display("FAIL err_buffer got=%h exp=%h", s, m_snap()); end
        if (stb_cnt != w0) begin bad++; $display("FAIL err_wrstb got=%0d exp=0", stb_cnt - w0); end
        send_cmd(8'h0C);
        total++;
        if (oERR !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", oERR); end
    endtask

    task automatic test_reset_mid();
        int n; int cnt; logic [255:0] s;
        for (int k = 0; k < 2; k++) begin
            send_cmd(8'h0C);
            strobe(0, 0, 8'h01, 4, 1);
            cnt = 0;
            while (oBUSY !== 1'b1 && cnt < 20) begin @(negedge iCLK); cnt++; end
            repeat (k == 0 ? 36 : 10) @(negedge iCLK);
            hold_reset();
            total += 3;
            if (oADDR !== 7'h00 || oENTRY_INC !== 1'b1)
                begin bad++; $display("FAIL mid%0d_addr_entry got=%h/%b exp=00/1", k, oADDR, oENTRY_INC); end
            if (oDISP_ON !== 0 || oERR !== 0 || oWR_STB !== 0 || oRD_CHAR !== 8'h00)
                begin bad++; $display("FAIL mid%0d_flags got disp=%b err=%b stb=%b rd=%h exp 0", k, oDISP_ON, oERR, oWR_STB, oRD_CHAR); end
            if (oBUSY !== 1'b1) begin bad++; $display("FAIL mid%0d_busy got=%b exp=1", k, oBUSY); end
            release_reset(n);
            read_all(s);
            total += 2;
            if (n != LONG) begin bad++; $display("FAIL mid%0d_busy_len got=%0d exp=%0d", k, n, LONG); end
            if (s !== m_snap()) begin bad++; $display("FAIL mid%0d_buffer got=%h exp=%h", k, s, m_snap()); end
        end
    endtask

    initial begin
        m_wr = 0;
        m_reset();
        test_reset();
        test_basic_seq();
        test_line2_gap();
        test_wrap();
        test_random();
        test_busy_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
